// File: rtl/cordic_iter_engine.sv
// rtl/cordic_iter_engine.sv - iterative CORDIC core, one micro-rotation per clock
module cordic_iter_engine #(
  parameter int DATA_W = 16,
  parameter int ITERS  = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  input  logic [DATA_W-1:0] X_i,
  input  logic [DATA_W-1:0] Y_i,
  input  logic [15:0]       Z_i,
  output logic              Ready,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] X_o,
  output logic [DATA_W-1:0] Y_o,
  output logic [15:0]       Z_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [3:0]        iter_q;
  logic              mode_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] x_q, y_q;
  logic [DATA_W-1:0] x_d, y_d;
  logic [DATA_W-1:0] x_sh, y_sh;
  logic [15:0]       z_q, z_d;
  logic [15:0]       atan_i;
  logic              d_pos;

  // atan(2^-i) in binary-angle units where 32768 = pi
  function automatic logic [15:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      4'd10:   atan_lut = 16'd10;
      4'd11:   atan_lut = 16'd5;
      4'd12:   atan_lut = 16'd3;
      4'd13:   atan_lut = 16'd1;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  // One micro-rotation: pick direction, shift arithmetically, wrap-around add/sub
  always_comb begin
    x_sh   = $signed(x_q) >>> iter_q;
    y_sh   = $signed(y_q) >>> iter_q;
    atan_i = atan_lut(iter_q);
    d_pos  = mode_q ? y_q[DATA_W-1] : ~z_q[15];
    if (d_pos) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_i;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_i;
    end
  end

  // Control FSM with registered status flags and working registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      iter_q  <= 4'd0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          x_q    <= x_d;
          y_q    <= y_d;
          z_q    <= z_d;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'(ITERS - 1)) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation
          done_q <= 1'b0;
          if (Start) begin
            state_q <= S_RUN;
            iter_q  <= 4'd0;
            mode_q  <= Mode;
            x_q     <= X_i;
            y_q     <= Y_i;
            z_q     <= Z_i;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign X_o   = x_q;
  assign Y_o   = y_q;
  assign Z_o   = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// tb/tb_cordic_iter_engine.sv - directed and model-based checks for cordic_iter_engine
module tb_cordic_iter_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               mode;
  logic signed [15:0] x_i, y_i, z_i;
  logic               ready, busy, done;
  logic signed [15:0] x_o, y_o, z_o;

  logic               c1_start;
  logic               c1_mode;
  logic signed [15:0] c1_x_i, c1_y_i, c1_z_i;
  logic               c1_ready, c1_busy, c1_done;
  logic signed [15:0] c1_x_o, c1_y_o, c1_z_o;

  int n_cmp = 0;
  int n_err = 0;

  int lut[15] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1};

  always #5 clk = ~clk;

  cordic_iter_engine #(.DATA_W(16), .ITERS(15)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .Mode(mode),
    .X_i(x_i), .Y_i(y_i), .Z_i(z_i),
    .Ready(ready), .Busy(busy), .Done(done),
    .X_o(x_o), .Y_o(y_o), .Z_o(z_o)
  );

  cordic_iter_engine #(.DATA_W(16), .ITERS(1)) dut1 (
    .Clk(clk), .Reset(reset), .Start(c1_start), .Mode(c1_mode),
    .X_i(c1_x_i), .Y_i(c1_y_i), .Z_i(c1_z_i),
    .Ready(c1_ready), .Busy(c1_busy), .Done(c1_done),
    .X_o(c1_x_o), .Y_o(c1_y_o), .Z_o(c1_z_o)
  );

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Golden CORDIC in integer arithmetic, truncated to 16 bits after each step
  task automatic ref_cordic(input logic m, input int x0, input int y0, input int z0, input int n,
                            output logic signed [15:0] xr, output logic signed [15:0] yr,
                            output logic signed [15:0] zr);
    logic signed [15:0] x, y, z, xs, ys;
    int d;
    x = 16'(x0);
    y = 16'(y0);
    z = 16'(z0);
    for (int i = 0; i < n; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (m) d = (y < 0) ? 1 : -1;
      else   d = (z >= 0) ? 1 : -1;
      xr = 16'(int'(x) - d * int'(ys));
      yr = 16'(int'(y) + d * int'(xs));
      zr = 16'(int'(z) - d * lut[i]);
      x = xr;
      y = yr;
      z = zr;
    end
    xr = x;
    yr = y;
    zr = z;
  endtask

  // Launch one operation on the main instance and wait (bounded) for Done
  task automatic run_op(input logic m, input int x, input int y, input int z,
                        output int cyc, output logic timed_out);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    x_i   = 16'(x);
    y_i   = 16'(y);
    z_i   = 16'(z);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    mode  = 1'b0;
    x_i   = 16'sd1234;
    y_i   = 16'sd55;
    z_i   = 16'sd100;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    n_cmp += 6;
    if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%0b want=1", ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b want=0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b want=0", done); end
    if (x_o !== 16'sd0) begin n_err++; $display("FAIL reset_x got=%0d want=0", x_o); end
    if (y_o !== 16'sd0) begin n_err++; $display("FAIL reset_y got=%0d want=0", y_o); end
    if (z_o !== 16'sd0) begin n_err++; $display("FAIL reset_z got=%0d want=0", z_o); end
  endtask

  task automatic test_rotation_45();
    int cyc;
    logic to;
    logic signed [15:0] ex, ey, ez;
    run_op(1'b0, 10000, 0, 8192, cyc, to);
    ref_cordic(1'b0, 10000, 0, 8192, 15, ex, ey, ez);
    n_cmp += 6;
    if (to || cyc != 16) begin n_err++; $display("FAIL rot45_latency got=%0d want=16", cyc); end
    if (ready !== 1'b1) begin n_err++; $display("FAIL rot45_ready got=%0b want=1", ready); end
    if (iabs(x_o - 11645) > 4) begin n_err++; $display("FAIL rot45_x got=%0d want=11645+-4", x_o); end
    if (iabs(y_o - 11645) > 4) begin n_err++; $display("FAIL rot45_y got=%0d want=11645+-4", y_o); end
    if (iabs(int'(z_o)) > 2) begin n_err++; $display("FAIL rot45_z got=%0d want=0+-2", z_o); end
    if ({x_o, y_o, z_o} !== {ex, ey, ez}) begin
      n_err++;
      $display("FAIL rot45_exact got=%0d,%0d,%0d want=%0d,%0d,%0d", x_o, y_o, z_o, ex, ey, ez);
    end
    // Done is a single-cycle pulse and results hold afterwards
    @(negedge clk);
    n_cmp += 2;
    if (done !== 1'b0) begin n_err++; $display("FAIL rot45_done_pulse got=%0b want=0", done); end
    if (x_o !== ex) begin n_err++; $display("FAIL rot45_hold got=%0d want=%0d", x_o, ex); end
  endtask

  task automatic test_vectoring();
    int cyc;
    logic to;
    logic signed [15:0] ex, ey, ez;
    run_op(1'b1, 10000, 10000, 0, cyc, to);
    ref_cordic(1'b1, 10000, 10000, 0, 15, ex, ey, ez);
    n_cmp += 4;
    if (to) begin n_err++; $display("FAIL vec_timeout got=%0d want=16", cyc); end
    if (iabs(x_o - 23289) > 4) begin n_err++; $display("FAIL vec_x got=%0d want=23289+-4", x_o); end
    if (iabs(int'(y_o)) > 3) begin n_err++; $display("FAIL vec_y got=%0d want=0+-3", y_o); end
    if (iabs(z_o - 8192) > 3) begin n_err++; $display("FAIL vec_z got=%0d want=8192+-3", z_o); end
    n_cmp++;
    if ({x_o, y_o, z_o} !== {ex, ey, ez}) begin
      n_err++;
      $display("FAIL vec_exact got=%0d,%0d,%0d want=%0d,%0d,%0d", x_o, y_o, z_o, ex, ey, ez);
    end
  endtask

  task automatic test_iters1();
    @(negedge clk);
    c1_start = 1'b1;
    c1_mode  = 1'b0;
    c1_x_i   = 16'sd100;
    c1_y_i   = 16'sd0;
    c1_z_i   = 16'sd0;
    @(negedge clk);
    c1_start = 1'b0;
    n_cmp++;
    if (c1_busy !== 1'b1) begin n_err++; $display("FAIL it1_busy got=%0b want=1", c1_busy); end
    @(negedge clk);
    n_cmp += 4;
    if (c1_done !== 1'b1) begin n_err++; $display("FAIL it1_done got=%0b want=1", c1_done); end
    if (c1_x_o !== 16'sd100) begin n_err++; $display("FAIL it1_x got=%0d want=100", c1_x_o); end
    if (c1_y_o !== 16'sd100) begin n_err++; $display("FAIL it1_y got=%0d want=100", c1_y_o); end
    if (c1_z_o !== -16'sd8192) begin n_err++; $display("FAIL it1_z got=%0d want=-8192", c1_z_o); end
  endtask

  task automatic test_negative();
    int cyc;
    logic to;
    run_op(1'b0, 10000, 0, -8192, cyc, to);
    n_cmp += 3;
    if (to) begin n_err++; $display("FAIL neg_timeout got=%0d want=16", cyc); end
    if (iabs(x_o - 11645) > 4) begin n_err++; $display("FAIL neg_x got=%0d want=11645+-4", x_o); end
    if (iabs(y_o + 11645) > 4) begin n_err++; $display("FAIL neg_y got=%0d want=-11645+-4", y_o); end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_low;
    logic signed [15:0] ex, ey, ez;
    ref_cordic(1'b0, 10000, 0, 8192, 15, ex, ey, ez);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; x_i = 16'sd10000; y_i = 16'sd0; z_i = 16'sd8192;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (cyc == 5) begin
        start = 1'b1; mode = 1'b1; x_i = -16'sd3000; y_i = 16'sd7000; z_i = -16'sd500;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_cmp += 2;
    if (cyc != 16) begin n_err++; $display("FAIL ignore_latency got=%0d want=16", cyc); end
    if ({x_o, y_o, z_o} !== {ex, ey, ez}) begin
      n_err++;
      $display("FAIL ignore_result got=%0d,%0d,%0d want=%0d,%0d,%0d", x_o, y_o, z_o, ex, ey, ez);
    end
    // Start in the DONE cycle
    ref_cordic(1'b1, 4000, -6000, 0, 15, ex, ey, ez);
    start = 1'b1; mode = 1'b1; x_i = 16'sd4000; y_i = -16'sd6000; z_i = 16'sd0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_low = 0;
    while (!done && cyc < 40) begin
      if (!busy) busy_low++;
      @(negedge clk);
      cyc++;
    end
    n_cmp += 3;
    if (cyc != 16) begin n_err++; $display("FAIL b2b_latency got=%0d want=16", cyc); end
    if (busy_low != 0) begin n_err++; $display("FAIL b2b_busy_gap got=%0d want=0", busy_low); end
    if ({x_o, y_o, z_o} !== {ex, ey, ez}) begin
      n_err++;
      $display("FAIL b2b_result got=%0d,%0d,%0d want=%0d,%0d,%0d", x_o, y_o, z_o, ex, ey, ez);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, done_seen;
    logic to;
    logic signed [15:0] ex, ey, ez;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; x_i = 16'sd10000; y_i = 16'sd0; z_i = 16'sd8192;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 8; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp += 6;
    if (ready !== 1'b1) begin n_err++; $display("FAIL rstrun_ready got=%0b want=1", ready); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstrun_busy got=%0b want=0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rstrun_done got=%0b want=0", done); end
    if (x_o !== 16'sd0) begin n_err++; $display("FAIL rstrun_x got=%0d want=0", x_o); end
    if (y_o !== 16'sd0) begin n_err++; $display("FAIL rstrun_y got=%0d want=0", y_o); end
    if (z_o !== 16'sd0) begin n_err++; $display("FAIL rstrun_z got=%0d want=0", z_o); end
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin n_err++; $display("FAIL rstrun_nodone got=%0d want=0", done_seen); end
    run_op(1'b0, -5000, 2000, 12000, cyc, to);
    ref_cordic(1'b0, -5000, 2000, 12000, 15, ex, ey, ez);
    n_cmp += 2;
    if (to || cyc != 16) begin n_err++; $display("FAIL rstrun_after_latency got=%0d want=16", cyc); end
    if ({x_o, y_o, z_o} !== {ex, ey, ez}) begin
      n_err++;
      $display("FAIL rstrun_after got=%0d,%0d,%0d want=%0d,%0d,%0d", x_o, y_o, z_o, ex, ey, ez);
    end
  endtask

  task automatic test_random();
    int cyc, x, y, z;
    logic to, m;
    logic signed [15:0] ex, ey, ez;
    for (int k = 0; k < 1000; k++) begin
      m = k[0];
      x = int'($urandom_range(16000)) - 8000;
      y = int'($urandom_range(16000)) - 8000;
      z = int'($urandom_range(32768)) - 16384;
      run_op(m, x, y, z, cyc, to);
      ref_cordic(m, x, y, z, 15, ex, ey, ez);
      n_cmp++;
      if (to || {x_o, y_o, z_o} !== {ex, ey, ez}) begin
        n_err++;
        $display("FAIL rand_%0d mode=%0b in=%0d,%0d,%0d got=%0d,%0d,%0d want=%0d,%0d,%0d",
                 k, m, x, y, z, x_o, y_o, z_o, ex, ey, ez);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; x_i = '0; y_i = '0; z_i = '0;
    c1_start = 1'b0; c1_mode = 1'b0; c1_x_i = '0; c1_y_i = '0; c1_z_i = '0;
    test_reset();
    test_rotation_45();
    test_vectoring();
    test_iters1();
    test_negative();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_iter_engine.md
# cordic_iter_engine

Parametrised iterative CORDIC core. It performs one micro-rotation per clock on X, Y and Z datapaths, using a shared internal arctangent table, and supports both rotation and vectoring modes. It supersedes the per-axis add/sub stage blocks, placing the X/Y/Z update, the direction decision, the shift and the iteration counter in one unit. It sits between the operand source and the downstream magnitude/phase or sin/cos consumers.

## Interface
Parameters:
- DATA_W, 16: X/Y width, signed two's complement, legal 8..32.
- ITERS, 15: number of micro-rotations, legal 1..15.

Ports:
- Clk  in  1  clock. Everything updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request. Sampled only when Ready=1.
- Mode  in  1  0 = rotation (drive Z→0), 1 = vectoring (drive Y→0). Captured with Start.
- X_i  in  DATA_W  signed X operand, captured with Start.
- Y_i  in  DATA_W  signed Y operand, captured with Start.
- Z_i  in  16  signed binary angle: ±32768 = ±π. Captured with Start.
- Ready  out  1  high in IDLE and DONE.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse; results are valid.
- X_o  out  DATA_W  X result register.
- Y_o  out  DATA_W  Y result register.
- Z_o  out  16  Z result register.

## Operation
States and transitions:
- IDLE → RUN on Start. Load X, Y, Z, Mode and set iter=0.
- RUN: perform iteration i=iter. Increment iter. After iteration ITERS-1, go to DONE.
- DONE: hold for 1 cycle with Done=1, then go to IDLE.
- DONE → RUN directly if Start=1, giving back-to-back operation.

Direction d per iteration:
- Rotation (Mode=0): d=+1 if Z≥0, else -1.
- Vectoring (Mode=1): d=+1 if Y<0, else -1.

Update rule:
- X' = X − d·(Y>>>i)
- Y' = Y + d·(X>>>i)
- Z' = Z − d·atan_lut[i]

Arithmetic and width rules:
- Shifts are arithmetic, so the sign is preserved.
- All sums wrap modulo 2^DATA_W (Z modulo 2^16). There is no saturation and no rounding.
- Gain K≈1.6468 (ITERS≥10) is not compensated; the consumer applies it.
- The caller keeps |X|,|Y| ≤ 2^(DATA_W-1)/2.
- In rotation mode the caller keeps |Z_i| ≤ 16384 (±π/2).

atan_lut contents:
- 16-bit constants round(atan(2^-i)·32768/π) for i=0..14.
- First entries: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1.

Output and control rules:
- X_o/Y_o/Z_o are the working registers. They change during RUN.
- X_o/Y_o/Z_o hold after DONE until the next accepted Start.
- Start while Busy=1 is ignored and has no effect on the operation in flight.
- Inputs are not sampled except on the accepting edge.
- Reset at any time, including mid-RUN, forces IDLE, clears iter and outputs, and drops the operation in flight with no Done.

## Timing
Reset values:
- State IDLE, Ready=1, Busy=0, Done=0.
- X_o=Y_o=Z_o=0, iter=0.

Latency:
- Start sampled at edge n gives Busy=1 from n+1 through n+ITERS.
- Done=1 and Ready=1 at n+ITERS+1.
- Start-to-Done latency is ITERS+1 cycles.

Throughput:
- One operation per ITERS+1 cycles when Start is held or re-asserted in DONE.

Simultaneous events:
- Reset=1 and Start=1 in the same cycle: Reset wins.
- Start in DONE: the new operation loads on that edge. Done is still 1 for that DONE cycle, and X_o/Y_o/Z_o show the new operands one cycle later.

## Test plan
- Rotation, DATA_W=16, ITERS=15: X_i=10000, Y_i=0, Z_i=8192 (45°) → Done at Start+16; X_o≈Y_o≈11645 ±4; |Z_o| ≤ 2.
- Vectoring: X_i=10000, Y_i=10000, Z_i=0 → X_o≈23289 ±4; |Y_o| ≤ 3; Z_o≈8192 ±3.
- ITERS=1, rotation: X_i=100, Y_i=0, Z_i=0 → after 2 cycles Done=1 with X_o=100, Y_o=100, Z_o=-8192.
- Start pulsed mid-RUN with different operands → ignored; results match the first operation exactly. Then Start in the DONE cycle → second Done exactly 16 cycles later, Busy never drops for more than 0 cycles.
- Reset asserted at RUN iteration 7 → next cycle Ready=1, Busy=0, X_o=Y_o=Z_o=0, no Done pulse; a subsequent Start completes normally.
- Negative quadrant, rotation: X_i=10000, Y_i=0, Z_i=-8192 → X_o≈11645, Y_o≈-11645 ±4; reference-model compare bit-exact over 1000 random in-range vectors in both modes.
